// File: rtl/oam_dma_ctrl_if.sv
// CPU register bus and OAM-side outputs of the OAM DMA engine.
// The master modport is the CPU/bench side; the slave modport is the DMA engine.
interface oam_dma_ctrl_if;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  reg_q;
    logic        reg_oe;
    logic [15:0] dma_a;
    logic        dma_run;
    logic        dma_wr;
    logic        vram_to_oam;
    logic        oam_addr_ndma;
    logic        dma_done;

    modport master (
        output cpu_wr, cpu_rd, a, d,
        input  reg_q, reg_oe, dma_a, dma_run, dma_wr, vram_to_oam, oam_addr_ndma, dma_done
    );

    modport slave (
        input  cpu_wr, cpu_rd, a, d,
        output reg_q, reg_oe, dma_a, dma_run, dma_wr, vram_to_oam, oam_addr_ndma, dma_done
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine: owns the source-page register and copies BYTES bytes from
// {src,8'h00} into OAM, one byte per M-cycle strobe.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG = 16'hFF46,
    parameter int          BYTES   = 160
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         mcyc,
    oam_dma_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(BYTES - 1);

    state_t      state, state_nxt;
    logic        rearm, rearm_nxt;
    logic [7:0]  src, src_nxt;
    logic [7:0]  idx, idx_nxt;
    logic [15:0] dma_a_q, dma_a_nxt;
    logic        dma_done_q, dma_done_nxt;
    logic        reg_wr;
    logic        run;

    // Echo RAM (E0..FF) mirrors work RAM 0x2000 lower.
    function automatic logic [7:0] eff_page(input logic [7:0] s);
        return (s >= 8'hE0) ? (s - 8'h20) : s;
    endfunction

    function automatic logic in_vram(input logic [7:0] s);
        return (s >= 8'h80) && (s <= 8'h9F);
    endfunction

    assign reg_wr = bus.cpu_wr && (bus.a == DMA_REG);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state      <= IDLE;
            rearm      <= 1'b0;
            src        <= 8'hFF;
            idx        <= 8'h00;
            dma_a_q    <= 16'h0000;
            dma_done_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            rearm      <= rearm_nxt;
            src        <= src_nxt;
            idx        <= idx_nxt;
            dma_a_q    <= dma_a_nxt;
            dma_done_q <= dma_done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rearm_nxt    = rearm;
        src_nxt      = reg_wr ? bus.d : src;
        idx_nxt      = idx;
        dma_a_nxt    = dma_a_q;
        dma_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                // A strobe coinciding with the write is not consumed here.
                if (reg_wr) begin
                    state_nxt = ARM;
                    rearm_nxt = 1'b0;
                end
            end
            ARM: begin
                if (!reg_wr && mcyc) begin
                    state_nxt = RUN;
                    idx_nxt   = 8'h00;
                    dma_a_nxt = {eff_page(src), 8'h00};
                end
            end
            RUN: begin
                // Restart wins over advancing; the byte strobed this edge is still written.
                if (reg_wr) begin
                    state_nxt = ARM;
                    rearm_nxt = 1'b1;
                    idx_nxt   = 8'h00;
                end else if (mcyc) begin
                    if (idx < LAST_IDX) begin
                        idx_nxt   = idx + 8'd1;
                        dma_a_nxt = {dma_a_q[15:8], idx + 8'd1};
                    end else begin
                        state_nxt    = IDLE;
                        dma_done_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // OAM stays owned across a restart so the PPU never sees a half-copied table.
    assign run               = (state == RUN) || ((state == ARM) && rearm);
    assign bus.dma_run       = run;
    assign bus.oam_addr_ndma = !run;
    assign bus.dma_wr        = (state == RUN) && mcyc;
    assign bus.dma_a         = dma_a_q;
    assign bus.dma_done      = dma_done_q;
    assign bus.vram_to_oam   = run && in_vram(src);
    assign bus.reg_q         = src;
    assign bus.reg_oe        = bus.cpu_rd && (bus.a == DMA_REG);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: a per-clock vector table plus hand-written
// sequences for full transfers, restart, reset abort and the idle-write corner.
module tb_oam_dma_ctrl;

    logic clk;
    logic nreset;
    logic mcyc;

    oam_dma_ctrl_if bus ();

    oam_dma_ctrl dut (
        .clk    (clk),
        .nreset (nreset),
        .mcyc   (mcyc),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        n;
        logic        w;
        logic        r;
        logic [15:0] a;
        logic [7:0]  d;
        logic        m;
        logic [7:0]  q;
        logic        oe;
        logic        run;
        logic        wr;
        logic [15:0] da;
        logic        vram;
        logic        ndma;
        logic        done;
    } vec_t;

    int checks;
    int failures;

    logic [7:0]  s_q;
    logic        s_oe, s_run, s_wr, s_vram, s_ndma, s_done;
    logic [15:0] s_a;

    int          wr_cnt, done_cnt, seq_err, vram_err, ndma_err, run_drop;
    logic [15:0] exp_base, last_a;
    logic        exp_vram, track_run;

    function automatic vec_t mk(logic n, logic w, logic r, logic [15:0] a, logic [7:0] d, logic m,
                                logic [7:0] q, logic oe, logic run, logic wr, logic [15:0] da,
                                logic vram, logic ndma, logic done);
        vec_t v;
        v.n = n; v.w = w; v.r = r; v.a = a; v.d = d; v.m = m;
        v.q = q; v.oe = oe; v.run = run; v.wr = wr; v.da = da;
        v.vram = vram; v.ndma = ndma; v.done = done;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, sample at the falling edge, return just after the rising edge.
    task automatic cyc(input logic n, input logic w, input logic r, input logic [15:0] ad,
                       input logic [7:0] dd, input logic m);
        nreset = n; bus.cpu_wr = w; bus.cpu_rd = r; bus.a = ad; bus.d = dd; mcyc = m;
        @(negedge clk);
        s_q = bus.reg_q; s_oe = bus.reg_oe; s_run = bus.dma_run; s_wr = bus.dma_wr;
        s_a = bus.dma_a; s_vram = bus.vram_to_oam; s_ndma = bus.oam_addr_ndma; s_done = bus.dma_done;
        if (s_wr) begin
            if (s_a !== exp_base + 16'(wr_cnt)) seq_err++;
            last_a = s_a;
            wr_cnt++;
        end
        if (s_done) done_cnt++;
        if (s_run && (s_vram !== exp_vram)) vram_err++;
        if (!s_run && s_vram) vram_err++;
        if (s_ndma !== !s_run) ndma_err++;
        if (track_run && !s_run) run_drop++;
        @(posedge clk);
        #1;
        bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; mcyc = 1'b0;
    endtask

    task automatic strobe();
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    endtask

    task automatic clr(input logic [15:0] base, input logic vr);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        wr_cnt = 0; done_cnt = 0; seq_err = 0; vram_err = 0; ndma_err = 0; run_drop = 0;
        exp_base = base; exp_vram = vr; track_run = 1'b0; last_a = 16'h0000;
    endtask

    task automatic transfer(input logic [7:0] src, input logic [7:0] page, input logic vr);
        clr({page, 8'h00}, vr);
        cyc(1'b1, 1'b1, 1'b0, 16'hFF46, src, 1'b0);
        strobe();
        chk("xfer_first_run", {31'd0, s_run}, 32'd1);
        chk("xfer_first_addr", {16'd0, s_a}, {16'd0, page, 8'h00});
        for (int k = 0; k < 160; k++) strobe();
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        chk("xfer_wr_count", wr_cnt, 160);
        chk("xfer_addr_seq_err", seq_err, 0);
        chk("xfer_last_addr", {16'd0, last_a}, {16'd0, page, 8'h9F});
        chk("xfer_done_count", done_cnt, 1);
        chk("xfer_vram_err", vram_err, 0);
        chk("xfer_ndma_err", ndma_err, 0);
        chk("xfer_end_idle", {30'd0, s_run, s_ndma}, 32'd1);
    endtask

    vec_t tbl [17];

    initial begin
        checks = 0; failures = 0;
        wr_cnt = 0; done_cnt = 0; seq_err = 0; vram_err = 0; ndma_err = 0; run_drop = 0;
        exp_base = 16'h0000; exp_vram = 1'b0; track_run = 1'b0; last_a = 16'h0000;
        nreset = 1'b0; mcyc = 1'b0;
        bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; bus.a = 16'h0000; bus.d = 8'h00;

        //            n  w  r  a         d      m   q      oe run wr dma_a     vr nd dn
        tbl[0]  = mk(1, 0, 0, 16'h0000, 8'h00, 0,  8'hFF, 0, 0, 0, 16'h0000, 0, 1, 0);
        tbl[1]  = mk(1, 0, 1, 16'hFF46, 8'h00, 0,  8'hFF, 1, 0, 0, 16'h0000, 0, 1, 0);
        tbl[2]  = mk(1, 1, 0, 16'hFF47, 8'h12, 1,  8'hFF, 0, 0, 0, 16'h0000, 0, 1, 0);
        tbl[3]  = mk(1, 0, 1, 16'hFF46, 8'h00, 0,  8'hFF, 1, 0, 0, 16'h0000, 0, 1, 0);
        tbl[4]  = mk(1, 1, 0, 16'hFF46, 8'hE3, 1,  8'hFF, 0, 0, 0, 16'h0000, 0, 1, 0);
        tbl[5]  = mk(1, 0, 1, 16'hFF46, 8'h00, 0,  8'hE3, 1, 0, 0, 16'h0000, 0, 1, 0);
        tbl[6]  = mk(1, 0, 0, 16'h0000, 8'h00, 1,  8'hE3, 0, 0, 0, 16'h0000, 0, 1, 0);
        tbl[7]  = mk(1, 0, 0, 16'h0000, 8'h00, 0,  8'hE3, 0, 1, 0, 16'hC300, 0, 0, 0);
        tbl[8]  = mk(1, 0, 0, 16'h0000, 8'h00, 1,  8'hE3, 0, 1, 1, 16'hC300, 0, 0, 0);
        tbl[9]  = mk(1, 0, 0, 16'h0000, 8'h00, 0,  8'hE3, 0, 1, 0, 16'hC301, 0, 0, 0);
        tbl[10] = mk(1, 1, 0, 16'hFF46, 8'h85, 1,  8'hE3, 0, 1, 1, 16'hC301, 0, 0, 0);
        tbl[11] = mk(1, 0, 0, 16'h0000, 8'h00, 0,  8'h85, 0, 1, 0, 16'hC301, 1, 0, 0);
        tbl[12] = mk(1, 0, 0, 16'h0000, 8'h00, 1,  8'h85, 0, 1, 0, 16'hC301, 1, 0, 0);
        tbl[13] = mk(1, 0, 0, 16'h0000, 8'h00, 0,  8'h85, 0, 1, 0, 16'h8500, 1, 0, 0);
        tbl[14] = mk(0, 0, 0, 16'h0000, 8'h00, 1,  8'h85, 0, 1, 1, 16'h8500, 1, 0, 0);
        tbl[15] = mk(1, 0, 0, 16'h0000, 8'h00, 1,  8'hFF, 0, 0, 0, 16'h0000, 0, 1, 0);
        tbl[16] = mk(1, 0, 0, 16'h0000, 8'h00, 0,  8'hFF, 0, 0, 0, 16'h0000, 0, 1, 0);

        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].n, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].m);
            chk($sformatf("vec%0d", i),
                {2'b00, s_q, s_oe, s_run, s_wr, s_a, s_vram, s_ndma, s_done},
                {2'b00, tbl[i].q, tbl[i].oe, tbl[i].run, tbl[i].wr, tbl[i].da,
                 tbl[i].vram, tbl[i].ndma, tbl[i].done});
        end

        // Full transfers, including VRAM-bus source classification.
        transfer(8'hC1, 8'hC1, 1'b0);
        transfer(8'h80, 8'h80, 1'b1);
        transfer(8'h9F, 8'h9F, 1'b1);
        transfer(8'hA0, 8'hA0, 1'b0);

        // Restart mid-transfer at dma_a=C140.
        clr(16'hC100, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 16'hFF46, 8'hC1, 1'b0);
        for (int k = 0; k < 65; k++) strobe();
        chk("rst_pre_count", wr_cnt, 64);
        chk("rst_pre_addr", {16'd0, s_a}, 32'h0000C140);
        track_run = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 16'hFF46, 8'hD0, 1'b0);
        exp_base = 16'hD000; wr_cnt = 0;
        strobe();
        chk("rst_gap_no_wr", wr_cnt, 0);
        chk("rst_new_addr", {16'd0, s_a}, 32'h0000D000);
        chk("rst_run_held", run_drop, 0);
        track_run = 1'b0;
        for (int k = 0; k < 160; k++) strobe();
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        chk("rst_post_count", wr_cnt, 160);
        chk("rst_last_addr", {16'd0, last_a}, 32'h0000D09F);
        chk("rst_seq_err", seq_err, 0);
        chk("rst_done_count", done_cnt, 1);

        // Reset abort at idx 0x50.
        clr(16'hC100, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 16'hFF46, 8'hC1, 1'b0);
        for (int k = 0; k < 81; k++) strobe();
        chk("abort_addr", {16'd0, s_a}, 32'h0000C150);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        chk("abort_state", {7'd0, s_run, s_a, s_q}, {7'd0, 1'b0, 16'h0000, 8'hFF});
        wr_cnt = 0;
        for (int k = 0; k < 4; k++) strobe();
        chk("abort_no_wr", wr_cnt, 0);
        chk("abort_no_done", done_cnt, 0);

        // Foreign address ignored; write coincident with a strobe in IDLE.
        clr(16'h5500, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 16'hFF47, 8'hC1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 16'hFF46, 8'h00, 1'b0);
        chk("ff47_reg", {23'd0, s_oe, s_q}, {23'd0, 1'b1, 8'hFF});
        strobe();
        strobe();
        chk("ff47_no_wr", wr_cnt, 0);
        cyc(1'b1, 1'b1, 1'b0, 16'hFF46, 8'h55, 1'b1);
        strobe();
        chk("coinc_first_no_wr", wr_cnt, 0);
        chk("coinc_addr", {16'd0, s_a}, 32'h00005500);
        strobe();
        chk("coinc_second_wr", wr_cnt, 1);
        chk("coinc_wr_addr", {16'd0, last_a}, 32'h00005500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
